// File: rtl/pci_arb_pkg.sv
// Shared types and defaults for the PCI round-robin arbiter.
// State encoding, ID width and default timer values.
package pci_arb_pkg;

  localparam int N_DEV_DEF       = 5;
  localparam int ID_W            = $clog2(N_DEV_DEF);
  localparam int LAT_TIMER_DEF   = 8;
  localparam int GNT_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    TURN  = 2'd3
  } state_t;

endpackage

// File: rtl/pci_rr_pick.sv
// Round-robin requester selection, combinational.
// Scans last+1, last+2, ... (mod N) and returns the first set bit.
module pci_rr_pick #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] win,
  output logic         vld
);

  // Walk from the farthest slot to the nearest so the nearest hit wins
  always_comb begin
    win = '0;
    vld = |req;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N])
        win = W'((int'(last) + k) % N);
    end
  end

endmodule

// File: rtl/pci_rr_arbiter.sv
// PCI central arbiter: round-robin grant, bus parking,
// latency-timer yield and grant timeout.
module pci_rr_arbiter
  import pci_arb_pkg::*;
#(
  parameter int N_DEV       = N_DEV_DEF,
  parameter int PARK_EN     = 1,
  parameter int PARK_ID     = 0,
  parameter int LAT_TIMER   = LAT_TIMER_DEF,
  parameter int GNT_TIMEOUT = GNT_TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_DEV-1:0]         req_n,
  input  logic                     frame_n,
  input  logic                     irdy_n,
  output logic [N_DEV-1:0]         gnt_n,
  output logic [$clog2(N_DEV)-1:0] owner_id,
  output logic                     owner_vld,
  output logic                     timeout
);

  localparam int IW   = $clog2(N_DEV);
  localparam int CMAX = (LAT_TIMER > GNT_TIMEOUT) ?
                        LAT_TIMER : GNT_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  state_t         state_q, state_d;
  logic [N_DEV-1:0] gnt_q, gnt_d;
  logic [IW-1:0]  own_q, own_d;
  logic [IW-1:0]  last_q, last_d;
  logic           vld_q, vld_d;
  logic           to_q, to_d;
  logic [CW-1:0]  lat_q, lat_d;
  logic [CW-1:0]  gcnt_q, gcnt_d;

  logic [N_DEV-1:0] req;
  logic [N_DEV-1:0] own_mask;
  logic [N_DEV-1:0] park_mask;
  logic [IW-1:0]  win;
  logic           any_req;
  logic           own_req;
  logic           others;
  logic           held;
  logic           parked;
  logic           direct;
  logic           bus_idle;
  logic           to_hit;
  logic [CW-1:0]  lat_nx;

  assign req       = ~req_n;
  assign own_mask  = N_DEV'(1) << own_q;
  assign park_mask = N_DEV'(1) << PARK_ID;
  assign own_req   = |(req & own_mask);
  assign others    = |(req & ~own_mask);
  assign held      = ~|(gnt_q & own_mask);
  assign parked    = (PARK_EN != 0) && !vld_q &&
                     ~|(gnt_q & park_mask);
  assign direct    = !parked || (win == IW'(PARK_ID));
  assign bus_idle  = frame_n & irdy_n;
  assign to_hit    = gcnt_q == CW'(GNT_TIMEOUT - 1);
  assign lat_nx    = (lat_q == CW'(LAT_TIMER)) ?
                     lat_q : lat_q + CW'(1);

  pci_rr_pick #(
    .N (N_DEV),
    .W (IW)
  ) u_pick (
    .req  (req),
    .last (last_q),
    .win  (win),
    .vld  (any_req)
  );

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '1;
      own_q   <= '0;
      last_q  <= IW'(N_DEV - 1);
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
      lat_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
      lat_q   <= lat_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (parked && !frame_n)
          state_d = BUSY;
        else if (any_req)
          state_d = direct ? GRANT : TURN;
      end
      GRANT: begin
        if (!frame_n)
          state_d = BUSY;
        else if (!own_req || to_hit)
          state_d = TURN;
      end
      BUSY: begin
        if (bus_idle)
          state_d = (!held || !own_req || others) ?
                    TURN : GRANT;
      end
      TURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of grants, owner, counters and timeout
  always_comb begin
    gnt_d  = gnt_q;
    own_d  = own_q;
    last_d = last_q;
    vld_d  = vld_q;
    to_d   = 1'b0;
    lat_d  = lat_q;
    gcnt_d = gcnt_q;
    unique case (state_q)
      IDLE: begin
        if (parked && !frame_n) begin
          own_d  = IW'(PARK_ID);
          vld_d  = 1'b1;
          last_d = IW'(PARK_ID);
          lat_d  = '0;
        end else if (any_req) begin
          if (direct) begin
            gnt_d  = ~(N_DEV'(1) << win);
            own_d  = win;
            vld_d  = 1'b1;
            gcnt_d = '0;
          end else begin
            gnt_d = '1;
            vld_d = 1'b0;
          end
        end else begin
          vld_d = 1'b0;
          if (PARK_EN != 0) begin
            gnt_d = ~park_mask;
            own_d = IW'(PARK_ID);
          end else begin
            gnt_d = '1;
          end
        end
      end
      GRANT: begin
        gcnt_d = gcnt_q + CW'(1);
        if (!frame_n) begin
          lat_d  = '0;
          last_d = own_q;
        end else if (!own_req) begin
          gnt_d = '1;
          vld_d = 1'b0;
        end else if (to_hit) begin
          gnt_d = '1;
          vld_d = 1'b0;
          to_d  = 1'b1;
        end
      end
      BUSY: begin
        lat_d = lat_nx;
        if (others && lat_nx == CW'(LAT_TIMER))
          gnt_d = '1;
        if (bus_idle) begin
          if (!held || !own_req || others) begin
            gnt_d = '1;
            vld_d = 1'b0;
          end else begin
            gcnt_d = '0;
          end
        end
      end
      TURN: begin
        gnt_d = '1;
        vld_d = 1'b0;
      end
      default: begin
        gnt_d = '1;
        vld_d = 1'b0;
      end
    endcase
  end

  assign gnt_n     = gnt_q;
  assign owner_id  = own_q;
  assign owner_vld = vld_q;
  assign timeout   = to_q;

endmodule
